seq_adder_acc: RTL and testbench

Parametrised, handshaked arithmetic unit for the next-generation adder tile. It supports add, subtract, accumulate and clear modes, with a registered result and a carry/borrow flag. Operands arrive via a valid/ready input channel; results leave via a valid/ready output channel held under backpressure. It sits between the input-switch decode and the display/output driver, and keeps a persistent accumulator plus a completed-operation counter.

---
 rtl/seq_adder_acc.sv | 129 ++++++++++++
 tb/tb_seq_adder_acc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_acc.sv
// Handshaked add/sub/accumulate/clear unit with a persistent accumulator and a handoff counter.
// Define ADDER_SAT_EN to make subtraction borrow and accumulator overflow saturate.
module seq_adder_acc #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_result,
  output logic                 out_flag,
  output logic [ACC_WIDTH-1:0] acc_value,
  output logic [CNT_WIDTH-1:0] op_count
);

  if (ACC_WIDTH < WIDTH + 1) begin : g_width_check
    $error("seq_adder_acc: ACC_WIDTH must be at least WIDTH+1");
  end

  localparam int unsigned PadW = ACC_WIDTH - WIDTH;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAcc = 2'b10;
  localparam logic [1:0] OpClr = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [1:0]           op_q;
  logic [ACC_WIDTH-1:0] result_q, acc_q;
  logic                 flag_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [ACC_WIDTH:0]   a_ext, b_ext, acc_sum;
  logic [ACC_WIDTH-1:0] ab_sum, diff;
  logic                 borrow;
  logic [ACC_WIDTH-1:0] result_d, acc_d;
  logic                 flag_d;

  assign a_ext   = {{(PadW + 1){1'b0}}, a_q};
  assign b_ext   = {{(PadW + 1){1'b0}}, b_q};
  // One extra bit so the accumulator carry-out is visible.
  assign acc_sum = {1'b0, acc_q} + a_ext + b_ext;
  assign ab_sum  = a_ext[ACC_WIDTH-1:0] + b_ext[ACC_WIDTH-1:0];
  assign diff    = a_ext[ACC_WIDTH-1:0] - b_ext[ACC_WIDTH-1:0];
  assign borrow  = (a_q < b_q);

  always_comb begin
    result_d = '0;
    flag_d   = 1'b0;
    acc_d    = acc_q;
    case (op_q)
      OpAdd: result_d = ab_sum;
      OpSub: begin
        flag_d = borrow;
`ifdef ADDER_SAT_EN
        result_d = borrow ? '0 : diff;
`else
        result_d = diff;
`endif
      end
      OpAcc: begin
        flag_d = acc_sum[ACC_WIDTH];
`ifdef ADDER_SAT_EN
        result_d = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
        result_d = acc_sum[ACC_WIDTH-1:0];
`endif
        acc_d = result_d;
      end
      OpClr: acc_d = '0;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAdd;
      result_q <= '0;
      flag_q   <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= in_op;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          result_q <= result_d;
          flag_q   <= flag_d;
          acc_q    <= acc_d;
          state_q  <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            count_q <= count_q + CNT_WIDTH'(1);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_flag   = flag_q;
  assign acc_value  = acc_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_seq_adder_acc.sv
// Scoreboard bench for seq_adder_acc: driver queues expected results, monitor checks handoffs.
module tb_seq_adder_acc;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAcc = 2'b10;
  localparam logic [1:0] OpClr = 2'b11;

`ifdef ADDER_SAT_EN
  localparam logic [7:0] SubNegR = 8'h00;
  localparam logic [7:0] Acc9R   = 8'd255;
`else
  localparam logic [7:0] SubNegR = 8'hFE;
  localparam logic [7:0] Acc9R   = 8'd14;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_flag;
  logic [7:0] acc_value;
  logic [7:0] op_count;

  seq_adder_acc #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flag  (out_flag),
    .acc_value (acc_value),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       f;
    logic [7:0] acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Monitor: a handshake is sampled on the falling edge ahead of the edge that completes it.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {24'd0, out_result}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {24'd0, out_result}, {24'd0, e.r});
        chk("flag", {31'd0, out_flag}, {31'd0, e.f});
        chk("acc_value", {24'd0, acc_value}, {24'd0, e.acc});
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [7:0] r, input logic f, input logic [7:0] acc);
    exp_t e;
    wait_idle();
    e.r = r;
    e.f = f;
    e.acc = acc;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    chk("out_valid_in_busy", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cnt_hold;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {24'd0, out_result}, 32'd0);
    chk("reset_flag", {31'd0, out_flag}, 32'd0);
    chk("reset_acc", {24'd0, acc_value}, 32'd0);
    chk("reset_count", {24'd0, op_count}, 32'd0);

    send(4'd9, 4'd7, OpAdd, 8'd16, 1'b0, 8'd0);
    wait_idle();
    chk("op_count_after_add", {24'd0, op_count}, 32'd1);
    send(4'd15, 4'd15, OpAdd, 8'd30, 1'b0, 8'd0);
    send(4'd3, 4'd5, OpSub, SubNegR, 1'b1, 8'd0);
    send(4'd9, 4'd4, OpSub, 8'd5, 1'b0, 8'd0);

    for (int k = 1; k <= 8; k++) send(4'd15, 4'd15, OpAcc, 8'(30 * k), 1'b0, 8'(30 * k));
    send(4'd15, 4'd15, OpAcc, Acc9R, 1'b1, Acc9R);
    wait_idle();
    chk("op_count_mid", {24'd0, op_count}, {24'd0, exp_cnt});

    // Backpressure: result must hold while new operands are offered and ignored.
    out_ready = 1'b0;
    send(4'd1, 4'd2, OpAdd, 8'd3, 1'b0, Acc9R);
    cnt_hold = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 4'(i + 8);
      in_b = 4'd6;
      in_op = OpAcc;
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {24'd0, out_result}, 32'd3);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_op_count", {24'd0, op_count}, {24'd0, cnt_hold});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("op_count_after_bp", {24'd0, op_count}, {24'd0, cnt_hold + 8'd1});

    send(4'd0, 4'd0, OpClr, 8'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 6; k++) send(4'd15, 4'd15, OpAcc, 8'(30 * k), 1'b0, 8'(30 * k));
    send(4'd10, 4'd10, OpAcc, 8'd200, 1'b0, 8'd200);
    send(4'd7, 4'd9, OpClr, 8'd0, 1'b0, 8'd0);
    send(4'd1, 4'd2, OpAcc, 8'd3, 1'b0, 8'd3);
    send(4'd15, 4'd15, OpAcc, 8'd33, 1'b0, 8'd33);
    send(4'd15, 4'd15, OpAcc, 8'd63, 1'b0, 8'd63);
    send(4'd15, 4'd15, OpAcc, 8'd93, 1'b0, 8'd93);
    send(4'd3, 4'd4, OpAcc, 8'd100, 1'b0, 8'd100);

    // Reset while an accumulate is in BUSY: nothing may come out.
    wait_idle();
    in_valid = 1'b1;
    in_a = 4'd5;
    in_b = 4'd5;
    in_op = OpAcc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    chk("acc_before_reset", {24'd0, acc_value}, 32'd100);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = '0;
    chk("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy_acc", {24'd0, acc_value}, 32'd0);
    chk("rst_busy_count", {24'd0, op_count}, 32'd0);
    chk("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy_result", {24'd0, out_result}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("no_result_after_reset", {31'd0, out_valid}, 32'd0);
    end

    send(4'd2, 4'd3, OpAdd, 8'd5, 1'b0, 8'd0);
    wait_idle();
    chk("op_count_after_reset", {24'd0, op_count}, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
